// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, requester ids, grant rule.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RELEASE   = 2'd3
    } arb_state_t;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_CORE  = 1'b1;

    // Pick the requester to serve. A lone full slot always wins; with both
    // full, fixed priority favours the fetch unit, round-robin favours
    // whichever requester was not served last.
    function automatic logic pick_grant(
        input logic full0,
        input logic full1,
        input logic last_served,
        input logic fixed_prio
    );
        if (full0 && full1) begin
            return fixed_prio ? REQ_FETCH : ~last_served;
        end else if (full1) begin
            return REQ_CORE;
        end else begin
            return REQ_FETCH;
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_tx_slot.sv
// One-byte holding slot per requester: capture on strobe, clear on completion, flag dropped strobes.
// Latency: a captured byte shows as full on the cycle after the strobe.
// Backpressure: none upstream; a strobe into a full slot is dropped and reported on overflow.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   capture/capture_dat strobe and byte from the requester
//   clear               owner's transfer finished (done or timeout); frees the slot
//   full, data          slot state and held byte
//   overflow            combinational pulse: this cycle's strobe was dropped
module tx_slot
    import uart_tx_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       capture,
    input  logic [7:0] capture_dat,
    input  logic       clear,
    output logic       full,
    output logic [7:0] data,
    output logic       overflow
);

    logic accept;

    // A clear in the same cycle frees the slot, so the incoming byte is taken
    // and the slot simply stays full.
    assign accept   = capture && (!full || clear);
    assign overflow = capture && full && !clear;

    always_ff @(posedge clk) begin
        if (!reset) begin
            full <= 1'b0;
            data <= 8'h00;
        end else if (accept) begin
            full <= 1'b1;
            data <= capture_dat;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two one-byte requesters (fetch unit, core) onto a single UART transmitter.
// Latency: strobe in cycle n gives tx_en in cycle n+2 when idle; completion to next grant >= 2 cycles.
// Backpressure: each requester sees busy while its slot is full; strobes into a full slot are dropped (ovf).
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-low reset
//   reqN_en, reqN_data          one-cycle strobe plus byte from requester N (0 = fetch, 1 = core)
//   reqN_busy                   requester N's slot is full
//   reqN_done                   one-cycle pulse, same cycle as the accepted tx_done
//   tx_en, tx_data              start strobe and byte towards the UART transmitter
//   tx_done                     completion pulse from the transmitter
//   owner, active               granted requester, transfer in progress
//   ovf                         sticky: a strobe was dropped
//   tmo                         one-cycle pulse when the watchdog aborts a transfer
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int WDOG_W     = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_en,
    input  logic [7:0] req0_data,
    output logic       req0_busy,
    output logic       req0_done,
    input  logic       req1_en,
    input  logic [7:0] req1_data,
    output logic       req1_busy,
    output logic       req1_done,
    output logic       tx_en,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       owner,
    output logic       active,
    output logic       ovf,
    output logic       tmo
);

    arb_state_t        state;
    logic              last_served;
    logic [WDOG_W-1:0] wdog;

    logic       full0, full1;
    logic [7:0] data0, data1;
    logic       ovf0, ovf1;
    logic       grant;
    logic       in_wait;
    logic       complete;
    logic       timeout;
    logic       clear0, clear1;

    assign in_wait  = (state == ST_WAIT_DONE);
    // tx_done wins over an expiring watchdog in the same cycle.
    assign complete = in_wait && tx_done;
    assign timeout  = in_wait && !tx_done && (&wdog);
    assign clear0   = (complete || timeout) && (owner == REQ_FETCH);
    assign clear1   = (complete || timeout) && (owner == REQ_CORE);
    assign grant    = pick_grant(full0, full1, last_served, FIXED_PRIO != 0);

    // Completion and timeout pulses land in the same cycle as the event that
    // causes them; gating with reset keeps a transfer abandoned by reset silent.
    assign req0_done = reset && complete && (owner == REQ_FETCH);
    assign req1_done = reset && complete && (owner == REQ_CORE);
    assign tmo       = reset && timeout;

    assign req0_busy = full0;
    assign req1_busy = full1;

    tx_slot u_slot0 (
        .clk         (clk),
        .reset       (reset),
        .capture     (req0_en),
        .capture_dat (req0_data),
        .clear       (clear0),
        .full        (full0),
        .data        (data0),
        .overflow    (ovf0)
    );

    tx_slot u_slot1 (
        .clk         (clk),
        .reset       (reset),
        .capture     (req1_en),
        .capture_dat (req1_data),
        .clear       (clear1),
        .full        (full1),
        .data        (data1),
        .overflow    (ovf1)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (ovf0 || ovf1) begin
            ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            owner       <= REQ_FETCH;
            tx_en       <= 1'b0;
            tx_data     <= 8'h00;
            active      <= 1'b0;
            last_served <= REQ_CORE;
            wdog        <= '0;
        end else begin
            tx_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (full0 || full1) begin
                        owner   <= grant;
                        tx_data <= grant ? data1 : data0;
                        tx_en   <= 1'b1;
                        active  <= 1'b1;
                        // Watchdog reads zero during LAUNCH and counts from
                        // there, so it hits all-ones 2^WDOG_W-1 cycles after LAUNCH.
                        wdog    <= '0;
                        state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    wdog  <= wdog + WDOG_W'(1);
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        last_served <= owner;
                        active      <= 1'b0;
                        state       <= ST_RELEASE;
                    end else if (&wdog) begin
                        active <= 1'b0;
                        state  <= ST_RELEASE;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_en, req1_en;
    logic [7:0] req0_data, req1_data;
    logic       req0_busy, req0_done, req1_busy, req1_done;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       tx_done_resp, tx_done_stim;
    logic       owner, active, ovf, tmo;

    assign tx_done = tx_done_resp | tx_done_stim;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.FIXED_PRIO(0), .WDOG_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_en   (req0_en),
        .req0_data (req0_data),
        .req0_busy (req0_busy),
        .req0_done (req0_done),
        .req1_en   (req1_en),
        .req1_data (req1_data),
        .req1_busy (req1_busy),
        .req1_done (req1_done),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .owner     (owner),
        .active    (active),
        .ovf       (ovf),
        .tmo       (tmo)
    );

    typedef struct { logic who; logic [7:0] data; int cyc; } tx_exp_t;
    typedef struct { logic who; int cyc; } done_exp_t;

    tx_exp_t   exp_tx[$];
    done_exp_t exp_done[$];
    int        exp_tmo[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   resp_on = 1'b1;
    bit   exp_ovf = 1'b0;
    logic mlast   = 1'b1;   // reference: last requester served

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event seen, want none expected (cycle %0d)", name, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_tx(input logic who, input logic [7:0] d, input int c);
        tx_exp_t e;
        e.who = who; e.data = d; e.cyc = c;
        exp_tx.push_back(e);
    endtask

    task automatic push_done(input logic who, input int c);
        done_exp_t e;
        e.who = who; e.cyc = c;
        exp_done.push_back(e);
    endtask

    // Strobe held for the current cycle; returns one cycle later.
    task automatic strobe(input logic en0, input logic [7:0] d0, input logic en1, input logic [7:0] d1);
        req0_en = en0; req0_data = d0; req1_en = en1; req1_data = d1;
        step(1);
        req0_en = 1'b0; req1_en = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done_stim = 1'b1;
        step(1);
        tx_done_stim = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_tx.size() != 0 || exp_done.size() != 0 || exp_tmo.size() != 0 || active) && t < 300) begin
            step(1);
            t++;
        end
        if (t >= 300) begin
            fail_evt("idle_timeout");
            exp_tx.delete(); exp_done.delete(); exp_tmo.delete();
        end
        step(3);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_en"},     tx_en,     0);
        check({tag, "_busy0"},     req0_busy, 0);
        check({tag, "_busy1"},     req1_busy, 0);
        check({tag, "_done0"},     req0_done, 0);
        check({tag, "_done1"},     req1_done, 0);
        check({tag, "_tmo"},       tmo,       0);
        check({tag, "_active"},    active,    0);
        check({tag, "_owner"},     owner,     0);
        check({tag, "_ovf"},       ovf,       0);
        check({tag, "_tx_data"},   tx_data,   0);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin : monitor
        tx_exp_t    te;
        done_exp_t  de;
        int         tc;
        logic [7:0] launched;
        launched = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_en) begin
                if (exp_tx.size() == 0) fail_evt("tx_en_unexpected");
                else begin
                    te = exp_tx.pop_front();
                    check("tx_data", tx_data, te.data);
                    check("owner", owner, te.who);
                    check("active_at_launch", active, 1);
                    if (te.cyc >= 0) check("launch_cycle", cyc, te.cyc);
                end
                launched = tx_data;
            end else if (active) begin
                check("tx_data_stable", tx_data, launched);
            end
            if (req0_done && req1_done) fail_evt("done_both");
            else if (req0_done || req1_done) begin
                if (exp_done.size() == 0) fail_evt("done_unexpected");
                else begin
                    de = exp_done.pop_front();
                    check("done_who", req1_done, de.who);
                    if (de.cyc >= 0) check("done_cycle", cyc, de.cyc);
                end
            end
            if (tmo) begin
                if (exp_tmo.size() == 0) fail_evt("tmo_unexpected");
                else begin
                    tc = exp_tmo.pop_front();
                    check("tmo_cycle", cyc, tc);
                end
            end
        end
    end

    // Transmitter model: answers each launch after a random delay.
    initial begin : responder
        int d;
        tx_done_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_en && resp_on) begin
                d = $urandom_range(1, 12);
                repeat (d) @(posedge clk);
                #2 tx_done_resp = 1'b1;
                @(posedge clk);
                #2 tx_done_resp = 1'b0;
            end
        end
    end

    initial begin : guard
        #1000000;
        $display("FAIL global_timeout: simulation still running, want finished");
        $fatal(1);
    end

    initial begin : stim
        int         c, kind;
        logic [7:0] a, b;
        logic       first, who;

        reset = 1'b0; req0_en = 1'b0; req1_en = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00; tx_done_stim = 1'b0;
        step(3);
        check_reset_vals("rst_init");
        reset = 1'b1;
        step(1);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 3);
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) pulse_done();   // stray completion while idle
            c = cyc;
            case (kind)
                0: begin
                    push_tx(1'b0, a, c + 2); push_done(1'b0, -1);
                    strobe(1'b1, a, 1'b0, 8'h00);
                    check("busy0_after_strobe", req0_busy, 1);
                    mlast = 1'b0;
                end
                1: begin
                    push_tx(1'b1, b, c + 2); push_done(1'b1, -1);
                    strobe(1'b0, 8'h00, 1'b1, b);
                    check("busy1_after_strobe", req1_busy, 1);
                    mlast = 1'b1;
                end
                2: begin
                    first = ~mlast;
                    push_tx(first, first ? b : a, c + 2); push_done(first, -1);
                    push_tx(~first, first ? a : b, -1);   push_done(~first, -1);
                    strobe(1'b1, a, 1'b1, b);
                    mlast = ~first;
                end
                default: begin
                    who = 1'($urandom_range(0, 1));
                    push_tx(who, a, c + 2); push_done(who, -1);
                    strobe(~who, a, who, a);
                    strobe(~who, b, who, b);
                    exp_ovf = 1'b1;
                    mlast = who;
                end
            endcase
            wait_idle();
            check("ovf_sticky", ovf, exp_ovf);
        end

        // Directed timing checks with a hand-driven transmitter.
        resp_on = 1'b0;
        wait_idle();
        reset = 1'b0;
        step(2);
        check_reset_vals("rst_mid");
        reset = 1'b1;
        exp_ovf = 1'b0;
        step(1);

        // Single send, queued follow-up, tx_done during LAUNCH ignored.
        c = cyc;
        push_tx(1'b0, 8'hA5, c + 2);  push_done(1'b0, c + 9);
        push_tx(1'b1, 8'h3C, c + 12); push_done(1'b1, c + 14);
        strobe(1'b1, 8'hA5, 1'b0, 8'h00);
        step(1);
        strobe(1'b0, 8'h00, 1'b1, 8'h3C);
        step(6);
        pulse_done();            // cycle c+9
        step(2);
        pulse_done();            // cycle c+12, LAUNCH: must be ignored
        step(1);
        pulse_done();            // cycle c+14
        wait_idle();

        // Refill on clear.
        c = cyc;
        push_tx(1'b0, 8'h54, c + 2); push_done(1'b0, c + 5);
        push_tx(1'b0, 8'h55, c + 8); push_done(1'b0, c + 11);
        strobe(1'b1, 8'h54, 1'b0, 8'h00);
        step(4);
        req0_en = 1'b1; req0_data = 8'h55; tx_done_stim = 1'b1;
        step(1);
        req0_en = 1'b0; tx_done_stim = 1'b0;
        check("refill_busy0", req0_busy, 1);
        step(5);
        pulse_done();            // cycle c+11
        wait_idle();
        check("refill_ovf", ovf, 0);

        // Watchdog timeout: 15 cycles after LAUNCH, slot freed, no done.
        c = cyc;
        push_tx(1'b0, 8'h77, c + 2);
        exp_tmo.push_back(c + 17);
        strobe(1'b1, 8'h77, 1'b0, 8'h00);
        wait_idle();
        check("tmo_slot_cleared", req0_busy, 0);
        c = cyc;
        push_tx(1'b0, 8'h78, c + 2); push_done(1'b0, c + 4);
        strobe(1'b1, 8'h78, 1'b0, 8'h00);
        step(3);
        pulse_done();
        wait_idle();

        // tx_done coinciding with expiry counts as completion.
        c = cyc;
        push_tx(1'b1, 8'h88, c + 2); push_done(1'b1, c + 17);
        strobe(1'b0, 8'h00, 1'b1, 8'h88);
        step(16);
        pulse_done();            // cycle c+17
        wait_idle();
        check("expiry_done_ovf", ovf, 0);

        // Overflow: second byte dropped, ovf sticky.
        c = cyc;
        push_tx(1'b1, 8'h33, c + 2); push_done(1'b1, c + 4);
        strobe(1'b0, 8'h00, 1'b1, 8'h33);
        strobe(1'b0, 8'h00, 1'b1, 8'h44);
        step(2);
        pulse_done();
        wait_idle();
        check("ovf_set", ovf, 1);
        step(10);
        check("ovf_held", ovf, 1);

        // Reset mid-WAIT_DONE abandons the transfer silently.
        c = cyc;
        push_tx(1'b1, 8'h99, c + 2);
        strobe(1'b0, 8'h00, 1'b1, 8'h99);
        step(3);
        reset = 1'b0; tx_done_stim = 1'b1;
        step(1);
        reset = 1'b1; tx_done_stim = 1'b0;
        check_reset_vals("rst_wait");
        pulse_done();
        step(3);

        // After reset, last-served is the core again: fetch wins a tie.
        resp_on = 1'b1;
        c = cyc;
        push_tx(1'b0, 8'h5A, c + 2); push_done(1'b0, -1);
        push_tx(1'b1, 8'hC3, -1);    push_done(1'b1, -1);
        strobe(1'b1, 8'h5A, 1'b1, 8'hC3);
        wait_idle();
        check("final_ovf", ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named clk and reset.
REQ-002 Parameter FIXED_PRIO, default 0, SHALL select arbitration: 0 = round-robin, 1 = requester 0 always wins.
REQ-003 Parameter WDOG_W, default 20, SHALL set the watchdog counter width; a transfer times out when the counter reaches all-ones.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 req0_en  input  1  one-cycle strobe: requester 0 (fetch unit) offers req0_data.
REQ-007 req0_data  input  8  byte from requester 0.
REQ-008 req0_busy  output  1  requester 0 holding slot is full.
REQ-009 req0_done  output  1  one-cycle pulse when requester 0's byte has completed.
REQ-010 req1_en, req1_data, req1_busy, req1_done SHALL be identical to REQ-006..009 for requester 1 (core).
REQ-011 tx_en  output  1  one-cycle start strobe to the UART transmitter.
REQ-012 tx_data  output  8  byte to the UART transmitter.
REQ-013 tx_done  input  1  one-cycle completion pulse from the UART transmitter.
REQ-014 owner  output  1  index of the requester currently granted.
REQ-015 active  output  1  high while a transfer is in progress (LAUNCH or WAIT_DONE).
REQ-016 ovf  output  1  sticky flag: a strobe was dropped because its slot was full.
REQ-017 tmo  output  1  one-cycle pulse when the watchdog aborts a transfer.

Function
REQ-018 Each requester SHALL own a one-byte holding slot; req_en while the slot is empty captures the data, and the slot is full from the next cycle.
REQ-019 req_en while the slot is full SHALL be dropped, leave the slot unchanged and set ovf.
REQ-020 If a slot is cleared and its req_en arrives in the same cycle, the new byte SHALL be captured and the slot SHALL stay full; ovf SHALL NOT be set.
REQ-021 FSM states SHALL be IDLE, LAUNCH, WAIT_DONE and RELEASE.
REQ-022 IDLE: if any slot is full, latch the grant into owner and go to LAUNCH; otherwise stay in IDLE.
REQ-023 Round-robin: with both slots full, grant the requester not served last; last-served resets to 1, so requester 0 wins first.
REQ-024 Single-slot case: the full slot SHALL be granted regardless of the last-served requester.
REQ-025 LAUNCH: tx_en = 1 for exactly one cycle, clear the watchdog, go to WAIT_DONE.
REQ-026 tx_data SHALL equal the owner's slot from LAUNCH through WAIT_DONE and SHALL stay stable there.
REQ-027 WAIT_DONE on tx_done: pulse reqN_done for the owner, clear the owner's slot, update last-served, go to RELEASE.
REQ-028 WAIT_DONE on watchdog all-ones without tx_done: pulse tmo, clear the owner's slot without pulsing reqN_done, go to RELEASE.
REQ-029 RELEASE: one idle gap cycle, then IDLE; a back-to-back grant therefore occurs no earlier than 2 cycles after tx_done.
REQ-030 tx_done outside WAIT_DONE SHALL be ignored.
REQ-031 tx_done and the watchdog expiring in the same cycle SHALL be treated as completion; tmo SHALL NOT pulse.
REQ-032 Latency: req_en in cycle n SHALL give tx_en in cycle n+2 when the block is idle.

Reset
REQ-033 While reset is low at a clock edge, state SHALL be IDLE; slots empty; ovf, tx_en, reqN_done, tmo, active and owner = 0; tx_data = 0; last-served = 1; watchdog = 0.
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer with no reqN_done or tmo pulse.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding and the requester index constants (REQ_FETCH = 0, REQ_CORE = 1).
REQ-036 A sub-module tx_slot (one-byte holding register with capture, clear and overflow detect) SHALL be instantiated once per requester.

Verification
REQ-037 Single send: req0_en with 8'hA5 in cycle 1 -> tx_en in cycle 3 with tx_data = A5; tx_done in cycle 10 -> req0_done in cycle 10, IDLE in cycle 12.
REQ-038 Contention: req0 = 8'h11 and req1 = 8'h22 strobed in the same cycle -> 11 is sent first, then 22; a second simultaneous pair -> 11 then 22 again (round-robin).
REQ-039 Overflow: req1_en with 8'h33 then 8'h44 while slot 1 is full -> 33 is sent, 44 is lost, ovf = 1 until reset.
REQ-040 Refill on clear: req0_en with 8'h55 in the same cycle that tx_done completes 8'h54 -> 55 is captured and sent next; ovf stays 0.
REQ-041 Timeout: WDOG_W = 4 with no tx_done -> tmo pulses 15 cycles after LAUNCH, slot is cleared, no req0_done.
REQ-042 Reset mid-WAIT_DONE -> all outputs take their REQ-033 values next cycle; a later tx_done produces no reqN_done.
